// File: rtl/acc_bank_if.sv
// acc_bank_if: operand, control, read-data and flag signals between the control unit and the accumulator bank.
interface acc_bank_if #(
  parameter int WIDTH   = 11,
  parameter int NUM_ACC = 4
);
  localparam int SELW = NUM_ACC > 1 ? $clog2(NUM_ACC) : 1;
  logic [WIDTH-1:0] acc_in;
  logic             acc_wr;
  logic [2:0]       acc_op;
  logic [SELW-1:0]  acc_sel;
  logic [WIDTH-1:0] acc_out;
  logic             acc_zero;
  logic             acc_neg;
  logic             acc_carry;
  logic             acc_ovf;
  modport master (output acc_in, acc_wr, acc_op, acc_sel,
                  input  acc_out, acc_zero, acc_neg, acc_carry, acc_ovf);
  modport slave  (input  acc_in, acc_wr, acc_op, acc_sel,
                  output acc_out, acc_zero, acc_neg, acc_carry, acc_ovf);
endinterface

// File: rtl/acc_bank.sv
// acc_bank: bank of NUM_ACC accumulators with eight read-modify-write ops and shared registered status flags.
module acc_bank #(
  parameter int WIDTH   = 11,
  parameter int NUM_ACC = 4,
  parameter int SAT_EN  = 0
) (
  input logic       clock,
  input logic       acc_reset,
  acc_bank_if.slave bus
);
  localparam int SELW = NUM_ACC > 1 ? $clog2(NUM_ACC) : 1;
  localparam logic [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};
  logic [WIDTH-1:0] acc [NUM_ACC];
  logic [SELW-1:0]  idx;
  logic             valid;
  logic [WIDTH-1:0] a, b, res;
  logic [WIDTH:0]   sum, dif;
  logic             add_v, sub_v, c, v;
  assign idx   = NUM_ACC == 1 ? '0 : bus.acc_sel;
  assign valid = int'(idx) < NUM_ACC;
  assign a     = valid ? acc[idx] : '0;
  assign b     = bus.acc_in;
  assign bus.acc_out = a;
  assign sum   = {1'b0, a} + {1'b0, b};
  assign dif   = {1'b0, a} - {1'b0, b};
  assign add_v = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
  assign sub_v = (a[WIDTH-1] != b[WIDTH-1]) && (dif[WIDTH-1] != a[WIDTH-1]);
  // on overflow the sign of A tells the direction, so it picks the clamp value
  always_comb begin
    res = a;
    c   = 1'b0;
    v   = 1'b0;
    case (bus.acc_op)
      3'd0: res = b;
      3'd1: begin
        res = (SAT_EN != 0 && add_v) ? (a[WIDTH-1] ? SMIN : SMAX) : sum[WIDTH-1:0];
        c   = sum[WIDTH];
        v   = add_v;
      end
      3'd2: begin
        res = (SAT_EN != 0 && sub_v) ? (a[WIDTH-1] ? SMIN : SMAX) : dif[WIDTH-1:0];
        c   = dif[WIDTH];
        v   = sub_v;
      end
      3'd3: res = a & b;
      3'd4: res = a | b;
      3'd5: res = a ^ b;
      3'd6: begin
        res = {a[WIDTH-2:0], 1'b0};
        c   = a[WIDTH-1];
        v   = a[WIDTH-1] ^ a[WIDTH-2];
      end
      default: begin
        res = {a[WIDTH-1], a[WIDTH-1:1]};
        c   = a[0];
      end
    endcase
  end
  always_ff @(posedge clock) begin
    if (acc_reset) begin
      for (int i = 0; i < NUM_ACC; i++) acc[i] <= '0;
      bus.acc_zero  <= 1'b1;
      bus.acc_neg   <= 1'b0;
      bus.acc_carry <= 1'b0;
      bus.acc_ovf   <= 1'b0;
    end else if (bus.acc_wr && valid) begin
      acc[idx]      <= res;
      bus.acc_zero  <= res == '0;
      bus.acc_neg   <= res[WIDTH-1];
      bus.acc_carry <= c;
      bus.acc_ovf   <= v;
    end
  end
endmodule

// File: tb/tb_acc_bank.sv
// tb_acc_bank: drives a wrapping 4-deep bank, a saturating 4-deep bank and a wrapping 3-deep bank in lockstep against a scoreboard.
module tb_acc_bank;
  localparam int W = 11;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;
  acc_bank_if #(.WIDTH(W), .NUM_ACC(4)) i0 ();
  acc_bank_if #(.WIDTH(W), .NUM_ACC(4)) i1 ();
  acc_bank_if #(.WIDTH(W), .NUM_ACC(3)) i2 ();
  acc_bank #(.WIDTH(W), .NUM_ACC(4), .SAT_EN(0)) d0 (.clock(clk), .acc_reset(rst), .bus(i0.slave));
  acc_bank #(.WIDTH(W), .NUM_ACC(4), .SAT_EN(1)) d1 (.clock(clk), .acc_reset(rst), .bus(i1.slave));
  acc_bank #(.WIDTH(W), .NUM_ACC(3), .SAT_EN(0)) d2 (.clock(clk), .acc_reset(rst), .bus(i2.slave));
  logic [14:0] o0, o1, o2;
  assign o0 = {i0.acc_out, i0.acc_zero, i0.acc_neg, i0.acc_carry, i0.acc_ovf};
  assign o1 = {i1.acc_out, i1.acc_zero, i1.acc_neg, i1.acc_carry, i1.acc_ovf};
  assign o2 = {i2.acc_out, i2.acc_zero, i2.acc_neg, i2.acc_carry, i2.acc_ovf};
  typedef struct {
    string       tag;
    int          k;
    logic [14:0] v;
  } exp_t;
  exp_t sb[$];
  int m_acc[3][4];
  logic [3:0] m_fl[3];
  int n_chk = 0;
  int n_fail = 0;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic model(input string tag, input int k, input logic r, input logic wr,
                       input logic [2:0] op, input int sel, input int b);
    int n, a, sa, sb_, s, u, res, c, v;
    n = (k == 2) ? 3 : 4;
    if (r) begin
      for (int i = 0; i < 4; i++) m_acc[k][i] = 0;
      m_fl[k] = 4'b1000;
    end else if (wr && sel < n) begin
      a   = m_acc[k][sel];
      sa  = a >= 1024 ? a - 2048 : a;
      sb_ = b >= 1024 ? b - 2048 : b;
      c = 0; v = 0; res = 0;
      case (op)
        3'd0: res = b;
        3'd1, 3'd2: begin
          u   = (op == 3'd1) ? a + b : a - b;
          res = (u + 2048) % 2048;
          c   = (op == 3'd1) ? int'(u >= 2048) : int'(a < b);
          s   = (op == 3'd1) ? sa + sb_ : sa - sb_;
          v   = int'(s > 1023 || s < -1024);
          if (k == 1 && v != 0) res = s > 1023 ? 1023 : 1024;
        end
        3'd3: res = a & b;
        3'd4: res = a | b;
        3'd5: res = a ^ b;
        3'd6: begin
          res = (a * 2) % 2048;
          c   = (a >> 10) & 1;
          v   = ((a >> 10) & 1) ^ ((a >> 9) & 1);
        end
        default: begin
          res = (a >> 1) | (a & 1024);
          c   = a & 1;
        end
      endcase
      m_acc[k][sel] = res;
      m_fl[k] = {res == 0, res >= 1024, c != 0, v != 0};
    end
    sb.push_back('{tag, k, {11'((sel < n) ? m_acc[k][sel] : 0), m_fl[k]}});
  endtask
  task automatic step(input string tag, input logic r, input logic wr, input logic [2:0] op,
                      input logic [1:0] sel, input logic [10:0] b);
    exp_t e;
    rst = r;
    i0.acc_wr = wr; i0.acc_op = op; i0.acc_sel = sel; i0.acc_in = b;
    i1.acc_wr = wr; i1.acc_op = op; i1.acc_sel = sel; i1.acc_in = b;
    i2.acc_wr = wr; i2.acc_op = op; i2.acc_sel = sel; i2.acc_in = b;
    for (int k = 0; k < 3; k++) model(tag, k, r, wr, op, int'(sel), int'(b));
    @(posedge clk);
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check($sformatf("%s/d%0d", e.tag, e.k), e.k == 0 ? o0 : e.k == 1 ? o1 : o2, e.v);
    end
  endtask
  initial begin
    for (int k = 0; k < 3; k++) begin
      m_fl[k] = 4'b1000;
      for (int i = 0; i < 4; i++) m_acc[k][i] = 0;
    end
    i0.acc_wr = 0; i0.acc_op = 0; i0.acc_sel = 0; i0.acc_in = 0;
    i1.acc_wr = 0; i1.acc_op = 0; i1.acc_sel = 0; i1.acc_in = 0;
    i2.acc_wr = 0; i2.acc_op = 0; i2.acc_sel = 0; i2.acc_in = 0;
    @(posedge clk);
    #1;
    step("rst", 1, 1, 3'd0, 2'd0, 11'h032);
    check("rst_val", o0, {11'h000, 4'b1000});
    for (int s = 0; s < 4; s++) step("rst_rd", 0, 0, 3'd0, 2'(s), 11'h000);
    step("ld50", 0, 1, 3'd0, 2'd1, 11'd50);
    step("add50", 0, 1, 3'd1, 2'd1, 11'd50);
    check("add50_val", o0, {11'h064, 4'b0000});
    step("iso_sel0", 0, 0, 3'd1, 2'd0, 11'd50);
    for (int i = 0; i < 3; i++) step("hold", 0, 0, 3'(i + 1), 2'd1, 11'h7FF);
    check("hold_val", o0, {11'h064, 4'b0000});
    step("ld3ff", 0, 1, 3'd0, 2'd2, 11'h3FF);
    step("add1_ovf", 0, 1, 3'd1, 2'd2, 11'h001);
    check("wrap_add", o0, {11'h400, 4'b0101});
    check("sat_add", o1, {11'h3FF, 4'b0001});
    step("ld400", 0, 1, 3'd0, 2'd2, 11'h400);
    step("sub1_ovf", 0, 1, 3'd2, 2'd2, 11'h001);
    check("wrap_sub", o0, {11'h3FF, 4'b0001});
    check("sat_sub", o1, {11'h400, 4'b0101});
    step("ld5", 0, 1, 3'd0, 2'd0, 11'd5);
    step("sub7", 0, 1, 3'd2, 2'd0, 11'd7);
    check("borrow", o0, {11'h7FE, 4'b0110});
    step("add2", 0, 1, 3'd1, 2'd0, 11'd2);
    check("carry_zero", o0, {11'h000, 4'b1010});
    step("ld_sh", 0, 1, 3'd0, 2'd3, 11'b10110010010);
    step("shl", 0, 1, 3'd6, 2'd3, 11'h000);
    check("shl_val", o0, {11'b01100100100, 4'b0011});
    step("ld_sh2", 0, 1, 3'd0, 2'd3, 11'b10110010010);
    step("asr", 0, 1, 3'd7, 2'd3, 11'h000);
    check("asr_val", o0, {11'b11011001001, 4'b0100});
    step("ld_sh3", 0, 1, 3'd0, 2'd3, 11'b11100000011);
    step("asr2", 0, 1, 3'd7, 2'd3, 11'h000);
    check("asr2_val", o0, {11'b11110000001, 4'b0110});
    step("logic_and", 0, 1, 3'd3, 2'd3, 11'h0F3);
    step("logic_or", 0, 1, 3'd4, 2'd3, 11'h400);
    step("logic_xor", 0, 1, 3'd5, 2'd3, 11'h5A5);
    for (int i = 0; i < 4; i++) step("mid_rst", i == 2, 1, 3'd1, 2'd2, 11'h001);
    check("mid_rst_val", o0, {11'h001, 4'b0000});
    step("ld7ff", 0, 1, 3'd0, 2'd0, 11'h7FF);
    step("oob_wr", 0, 1, 3'd0, 2'd3, 11'h005);
    check("oob_ignore", o2, {11'h000, 4'b0100});
    repeat (80) step("rnd", $urandom_range(0, 24) == 0, $urandom_range(0, 3) != 0,
                     3'($urandom), 2'($urandom), 11'($urandom));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/acc_bank.md
Name: acc_bank

Overview:
- Parametrised successor to the single accumulator register: a bank of NUM_ACC accumulators, each WIDTH bits wide.
- Every accumulator supports eight read-modify-write operations against acc_in, including arithmetic, logic and shift operations.
- Status flags (zero, negative, carry, overflow) are registered, and optional signed saturation is available.
- Sits between the datapath ALU input bus and the control unit, which reads the flags for conditional branching.

Parameters:
- WIDTH, 11, data width of acc_in, acc_out and each accumulator.
- NUM_ACC, 4, number of accumulators in the bank (1..16).
- SAT_EN, 0, 1 = ADD/SUB clamp to the signed max/min on overflow; 0 = wrap.

Ports:
- clock  in  1  rising-edge clock.
- acc_reset  in  1  synchronous, active-high reset.
- acc_in  in  WIDTH  operand / load data.
- acc_wr  in  1  perform acc_op on the selected accumulator at this edge.
- acc_op  in  3  operation code.
- acc_sel  in  SELW = max(1, clog2(NUM_ACC))  accumulator index, used for both write and read.
- acc_out  out  WIDTH  current value of acc[acc_sel] (combinational read of registers).
- acc_zero  out  1  registered flag: last written result == 0.
- acc_neg  out  1  registered flag: last written result MSB.
- acc_carry  out  1  registered flag: carry, borrow or shifted-out bit.
- acc_ovf  out  1  registered flag: signed overflow.

Behaviour:
- One clock; acc_reset is synchronous, active-high, and takes priority over acc_wr at the same edge.
- Reset values: all accumulators = 0; acc_zero = 1; acc_neg, acc_carry, acc_ovf = 0. acc_out therefore reads 0 for every valid sel.
- acc_wr = 0: all accumulators and flags hold, regardless of acc_op and acc_in.
- acc_wr = 1 at a rising edge: acc[acc_sel] <= f(acc[acc_sel], acc_in). Flags are updated from the written result. Other accumulators hold.
- Latency: the result is visible on acc_out (with acc_sel unchanged) and on the flags immediately after the edge, i.e. one cycle.
- Back-to-back acc_wr on consecutive cycles is legal; each operation uses the value written by the previous one.
- acc_op encoding (A = old acc[acc_sel], B = acc_in):
  - 000 LOAD: A <= B; carry = 0, ovf = 0.
  - 001 ADD: A + B; carry = unsigned carry out of bit WIDTH-1; ovf = signed overflow.
  - 010 SUB: A - B; carry = borrow (A < B unsigned); ovf = signed overflow.
  - 011 AND, 100 OR, 101 XOR: bitwise; carry = 0, ovf = 0.
  - 110 SHL: A << 1, LSB filled with 0; carry = A[WIDTH-1]; ovf = A[WIDTH-1] ^ A[WIDTH-2].
  - 111 ASR: arithmetic shift right by 1, MSB replicated; carry = A[0]; ovf = 0.
- Saturation (SAT_EN = 1, ADD/SUB only):
  - On signed overflow, the result clamps to 0111…1 (positive overflow) or 1000…0 (negative overflow).
  - acc_ovf is still set to 1; carry is computed from the unclamped operation.
- acc_zero and acc_neg are always computed from the value actually written, i.e. post-saturation.
- acc_sel >= NUM_ACC (non-power-of-two NUM_ACC): the write is ignored, the flags hold, and acc_out = 0.
- NUM_ACC = 1: acc_sel is ignored and the block degenerates to a single accumulator.
- The flags are shared by the whole bank and always reflect the most recent write to any accumulator.
- Changing acc_sel without acc_wr changes only acc_out, never the flags.
- All arithmetic is performed in WIDTH+1 bits internally; results are truncated to WIDTH bits.

Test Plan:
1. Reset: assert acc_reset for one edge with acc_wr = 1, acc_op = LOAD, acc_in = 11'h032 -> all accumulators read 0 on every sel; acc_zero = 1; other flags = 0.
2. Load/add with isolation: sel = 1, LOAD 11'b00000110010 (50), then ADD 50 -> acc_out = 100 (11'h064); zero = 0, neg = 0, carry = 0, ovf = 0. sel = 0 still reads 0. Drop acc_wr for 3 cycles -> value and flags unchanged.
3. Overflow: LOAD 11'h3FF, ADD 1.
   - SAT_EN = 0 -> 11'h400, ovf = 1, neg = 1, carry = 0.
   - SAT_EN = 1 -> 11'h3FF, ovf = 1, neg = 0.
   - LOAD 11'h400, SUB 1 with SAT_EN = 1 -> 11'h400, ovf = 1.
4. Subtract with borrow: LOAD 5, SUB 7 -> 11'h7FE (-2); carry = 1, neg = 1, ovf = 0. Then ADD 2 -> 0; zero = 1, carry = 1 (unsigned 11'h7FE + 2 carries out).
5. Shifts: LOAD 11'b10110010010.
   - SHL -> 11'b01100100100; carry = 1, ovf = 1, neg = 0.
   - Reload the same value, ASR -> 11'b11011001001; carry = 0, neg = 1.
   - LOAD 11'b11100000011, ASR -> 11'b11110000001; carry = 1.
6. Reset mid-stream and range check:
   - Alternate ADD 1 on sel 2 for 4 cycles, asserting acc_reset together with acc_wr on the 3rd -> value 0 after that edge, then 1 after the 4th.
   - With NUM_ACC = 3, a write to sel = 3 -> ignored: flags unchanged, acc_out = 0.
